// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache controller with a single
// outstanding refill to backing memory and saturating hit/miss counters.
module icache_ctrl #(
   parameter int unsigned LINES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   input  logic        invalidate_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
);

   localparam int unsigned IW = $clog2(LINES);
   localparam int unsigned TW = 30 - IW;

   typedef enum logic {StIdle, StWaitMem} state_e;

   state_e state_q, state_d;

   logic [LINES-1:0] valid_q;
   logic [TW-1:0]    tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   logic [31:0] instr_q;
   logic        instr_valid_q;
   logic        mem_req_q;
   logic [31:0] mem_addr_q;
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   logic [IW-1:0] idx;
   logic [IW-1:0] refill_idx;
   logic [TW-1:0] tag;
   logic          lookup_hit;
   logic          fetch;
   logic          idle_hit;
   logic          idle_miss;
   logic          refill;

   // Byte offset of the fetch address is irrelevant to a word cache.
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^pc_i[1:0];

   assign idx        = pc_i[IW+1:2];
   assign tag        = pc_i[31:IW+2];
   assign refill_idx = mem_addr_q[IW+1:2];
   assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
   assign fetch      = req_i && !flush_i;
   assign idle_hit   = (state_q == StIdle) && fetch && lookup_hit;
   assign idle_miss  = (state_q == StIdle) && fetch && !lookup_hit;
   assign refill     = (state_q == StWaitMem) && mem_rvalid_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (idle_miss) state_d = StWaitMem;
         StWaitMem: if (mem_rvalid_i) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      stall_o = 1'b0;
      unique case (state_q)
         StIdle:    stall_o = fetch && !lookup_hit;
         StWaitMem: stall_o = 1'b1;
         default:   stall_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q       <= '0;
         instr_q       <= 32'h0000_0013;
         instr_valid_q <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         hit_cnt_q     <= '0;
         miss_cnt_q    <= '0;
      end else begin
         instr_valid_q <= idle_hit;
         if (idle_hit) begin
            instr_q <= data_q[idx];
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (idle_miss) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {pc_i[31:2], 2'b00};
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
         end else if (refill) begin
            mem_req_q <= 1'b0;
         end
         // Invalidate beats a coincident refill: the line is written but stays invalid.
         if (invalidate_i) begin
            valid_q <= '0;
         end else if (refill) begin
            valid_q[refill_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (refill) begin
         tag_q[refill_idx]  <= mem_addr_q[31:IW+2];
         data_q[refill_idx] <= mem_rdata_i;
      end
   end

   assign instr_o       = instr_q;
   assign instr_valid_o = instr_valid_q;
   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = mem_addr_q;
   assign hit_cnt_o     = hit_cnt_q;
   assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized bench for icache_ctrl: fetch, memory and invalidate traffic checked
// every cycle against an array-based model of the cache contents and counters.
module tb_icache_ctrl;

   localparam int unsigned LINES = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic [31:0] pc_i;
   logic        flush_i;
   logic        invalidate_i;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   icache_ctrl #(.LINES(LINES)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .pc_i         (pc_i),
      .flush_i      (flush_i),
      .invalidate_i (invalidate_i),
      .instr_o      (instr_o),
      .instr_valid_o(instr_valid_o),
      .stall_o      (stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .hit_cnt_o    (hit_cnt_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: cache contents as plain arrays, one outstanding refill.
   bit          m_busy;
   bit          m_mreq;
   logic [31:0] m_addr;
   bit          m_valid [LINES];
   logic [31:0] m_tag   [LINES];
   logic [31:0] m_data  [LINES];
   logic [31:0] m_instr;
   bit          m_iv;
   logic [31:0] m_hits;
   logic [31:0] m_misses;

   function automatic int unsigned line_of(input logic [31:0] a);
      return (a / 4) % LINES;
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a);
      return a / (4 * LINES);
   endfunction

   task automatic model_reset();
      m_busy = 0;
      m_mreq = 0;
      m_addr = 32'h0;
      for (int i = 0; i < LINES; i++) m_valid[i] = 0;
      m_instr  = 32'h0000_0013;
      m_iv     = 0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic check_outputs(input string where);
      check({where, ".instr_valid"}, {31'b0, instr_valid_o}, {31'b0, m_iv});
      check({where, ".instr"}, instr_o, m_instr);
      check({where, ".mem_req"}, {31'b0, mem_req_o}, {31'b0, m_mreq});
      check({where, ".mem_addr"}, mem_addr_o, m_addr);
      check({where, ".hits"}, hit_cnt_o, m_hits);
      check({where, ".misses"}, miss_cnt_o, m_misses);
   endtask

   initial begin
      int unsigned lat;
      bit          hold;
      bit          stale;
      bit          did_reset;
      bit          hit;
      bit          exp_stall;
      int unsigned li;

      rst_i        = 1'b1;
      req_i        = 1'b0;
      pc_i         = 32'h0;
      flush_i      = 1'b0;
      invalidate_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      model_reset();
      repeat (2) @(negedge clk_i);
      check_outputs("reset");
      rst_i     = 1'b0;
      lat       = 0;
      hold      = 0;
      stale     = 0;
      did_reset = 0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk_i);
         // Reset in the middle of a refill; the memory answers afterwards.
         if (!did_reset && cyc > 2000 && m_busy) begin
            rst_i        = 1'b1;
            req_i        = 1'b0;
            flush_i      = 1'b0;
            invalidate_i = 1'b0;
            mem_rvalid_i = 1'b0;
            #1;
            model_reset();
            check_outputs("midreset");
            check("midreset.stall", {31'b0, stall_o}, 32'h0);
            @(negedge clk_i);
            rst_i     = 1'b0;
            did_reset = 1;
            hold      = 0;
            stale     = 1;
            continue;
         end

         if (!hold) begin
            req_i   = ($urandom % 4) != 0;
            pc_i    = $urandom_range(0, 3) * LINES * 4 + $urandom_range(0, 7) * 4
                      + $urandom_range(0, 3);
            flush_i = ($urandom % 8) == 0;
         end else begin
            flush_i = m_busy ? (($urandom % 4) == 0) : 1'b0;
         end
         invalidate_i = ($urandom % 16) == 0;

         if (stale) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
            stale        = 0;
         end else if (m_busy) begin
            if (lat == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = $urandom;
            end else begin
               mem_rvalid_i = 1'b0;
               lat--;
            end
         end else begin
            mem_rvalid_i = ($urandom % 20) == 0;
            mem_rdata_i  = $urandom;
         end

         #1;
         li        = line_of(pc_i);
         hit       = m_valid[li] && (m_tag[li] == tag_of(pc_i));
         exp_stall = m_busy || (req_i && !flush_i && !hit);
         check("stall", {31'b0, stall_o}, {31'b0, exp_stall});
         hold = exp_stall;

         m_iv = 0;
         if (!m_busy) begin
            if (req_i && !flush_i) begin
               if (hit) begin
                  m_instr = m_data[li];
                  m_iv    = 1;
                  if (m_hits != 32'hFFFF_FFFF) m_hits++;
               end else begin
                  m_busy = 1;
                  m_mreq = 1;
                  m_addr = pc_i & ~32'h3;
                  if (m_misses != 32'hFFFF_FFFF) m_misses++;
                  lat = $urandom_range(0, 4);
               end
            end
         end else if (mem_rvalid_i) begin
            m_data[line_of(m_addr)]  = mem_rdata_i;
            m_tag[line_of(m_addr)]   = tag_of(m_addr);
            m_valid[line_of(m_addr)] = 1;
            m_busy = 0;
            m_mreq = 0;
         end
         if (invalidate_i) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 0;
         end

         @(posedge clk_i);
         #1;
         check_outputs("cycle");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
